fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter sequencer and fetch controller that drives the 256-word instruction memory and hands instructions to decode.
- Holds the PC and presents the word address to the instruction memory.
- Registers the returned instruction into a one-entry output stage with a valid/ready handshake.
- Applies branch/jump redirects and stops on a halt instruction or an out-of-range fetch.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after start
IMEM_DEPTH, 256, instruction memory depth in words; fetches at or beyond it fault
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops the sequencer when consumed

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level; leaves IDLE when sampled high
imem_addr  output  32  word address to instruction memory = {2'b00, pc[31:2]}
imem_instr  input  32  combinational read data for imem_addr
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_ready  input  1  decode accepts this cycle
if_instr  output  32  registered instruction
if_pc  output  32  byte address of if_instr
br_taken  input  1  branch taken for the instruction being consumed
br_offset  input  16  signed word offset of that branch
jmp_taken  input  1  jump for the instruction being consumed
jmp_target  input  26  jump word index
halted  output  1  HALT state
fault  output  1  FAULT state

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, fault=0.
- imem_addr is always combinational from pc.
- States:
  - IDLE: no fetch; start=1 -> RUN.
  - RUN: fetch active.
  - HALT: terminal until reset.
  - FAULT: terminal until reset.
- consume = if_valid & if_ready.
- Load condition in RUN: (!if_valid | consume) and no redirect. On load: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+4 (32-bit wrap).
- Latency: pc presented in cycle N -> if_valid=1 with that instruction in N+1.
- Stall: if_valid=1 & if_ready=0 -> if_instr, if_pc, if_valid and pc all hold.
- Redirect: sampled only when consume=1; br_taken/jmp_taken ignored otherwise.
  - Jump has priority over branch.
  - Jump target: pc <= {if_pc_plus4[31:28], jmp_target, 2'b00}.
  - Branch target: pc <= if_pc+4 + (sign-extended br_offset << 2).
  - On redirect, if_valid<=0 (one bubble) and the memory data that cycle is discarded.
- Halt: consume with if_instr==HALT_INSTR -> HALT, if_valid<=0, halted=1. Any redirect on that cycle is ignored; pc holds.
- Fault: on a load attempt with pc[31:2] >= IMEM_DEPTH -> FAULT, fault=1, if_valid<=0, pc holds, no load. A consume in that same cycle completes normally.
- Misaligned pc (pc[1:0]!=0) is impossible by construction: all targets are word-aligned.
- start is ignored outside IDLE.
- Reset mid-operation: immediate return to reset values; an in-flight instruction is dropped.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (count of loads), perf_stalls[31:0] (cycles with if_valid & !if_ready) and perf_redirects[31:0].
  - Counters are cleared by rst_n, saturate at all-ones and freeze in HALT/FAULT.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, start=1 one cycle, memory words 0..3 = 32'h11,22,33,44, if_ready=1 -> if_valid first high 2 cycles after start; if_pc 0,4,8,12; if_instr 11,22,33,44 on consecutive cycles.
2. Hold if_ready=0 for 3 cycles while if_pc=4 -> if_instr=22 and imem_addr=2 stable for those 3 cycles; release -> if_pc 8 next.
3. Consume if_pc=8 with br_taken=1, br_offset=16'hFFFE -> one bubble, then if_pc=4. Repeat with jmp_taken=1 and br_taken=1, jmp_target=26'd10 -> next if_pc=40 (jump wins).
4. Word 5 = HALT_INSTR, consumed -> halted=1 next cycle; if_valid stays 0; start pulses have no effect; rst_n low -> halted=0.
5. IMEM_DEPTH=4, straight-line run -> after if_pc=12 loads, fault=1 with pc=16; if_valid drops after the pc=12 instruction is consumed.
6. Assert rst_n low mid-stall with if_valid=1 -> if_valid=0, pc=RESET_PC immediately (asynchronous, without a clock edge).

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC sequencer / fetch controller: word-addressed imem, one-entry output stage,
// branch/jump redirects, halt and out-of-range fault. `define FETCH_PERF_EN adds perf counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jmp_taken,
    input  logic [25:0] jmp_target,
    output logic        halted,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_redirects,
`endif
    output logic        fault
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic        halted_q;
    logic        fault_q;

    logic        consume;
    logic        redirect;
    logic        is_halt;
    logic        want_load;
    logic        oob;
    logic        do_load;
    logic [31:0] ifpc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;

    assign imem_addr  = {2'b00, pc_q[31:2]};
    assign consume    = if_valid_q & if_ready;
    assign is_halt    = consume & (if_instr_q == HALT_INSTR);
    assign redirect   = consume & (br_taken | jmp_taken) & ~is_halt;
    assign want_load  = ~if_valid_q | consume;
    assign oob        = ({2'b00, pc_q[31:2]} >= IMEM_DEPTH);
    assign do_load    = (state_q == S_RUN) & want_load & ~is_halt & ~redirect & ~oob;
    assign ifpc_plus4 = if_pc_q + 32'd4;
    assign br_tgt     = ifpc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign jmp_tgt    = {ifpc_plus4[31:28], jmp_target, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_q <= S_RUN;
                S_RUN: begin
                    if (is_halt) begin
                        // Halt wins over any redirect presented with it; pc holds.
                        state_q    <= S_HALT;
                        halted_q   <= 1'b1;
                        if_valid_q <= 1'b0;
                    end else if (redirect) begin
                        pc_q       <= jmp_taken ? jmp_tgt : br_tgt;
                        if_valid_q <= 1'b0;
                    end else if (want_load) begin
                        if (oob) begin
                            state_q    <= S_FAULT;
                            fault_q    <= 1'b1;
                            if_valid_q <= 1'b0;
                        end else begin
                            if_instr_q <= imem_instr;
                            if_pc_q    <= pc_q;
                            if_valid_q <= 1'b1;
                            pc_q       <= pc_q + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign halted   = halted_q;
    assign fault    = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, stalls_q, redirects_q;
    logic        in_run;
    assign in_run = (state_q == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q   <= 32'h0;
            stalls_q    <= 32'h0;
            redirects_q <= 32'h0;
        end else if (in_run) begin
            if (do_load && fetched_q != '1) fetched_q <= fetched_q + 32'd1;
            if (if_valid_q && !if_ready && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
            if (redirect && redirects_q != '1) redirects_q <= redirects_q + 32'd1;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_stalls    = stalls_q;
    assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: default-depth instance plus an IMEM_DEPTH=4 instance for the fault path.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, if_ready, br_taken, jmp_taken;
    logic [15:0] br_offset;
    logic [25:0] jmp_target;

    logic [31:0] addr0, instr0, ifi0, ifp0;
    logic        v0, h0, f0;
    logic [31:0] addr1, instr1, ifi1, ifp1;
    logic        v1, h1, f1;

    logic [31:0] mem [256];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign instr0 = mem[addr0[7:0]];
    assign instr1 = mem[addr1[7:0]];

    fetch_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(addr0), .imem_instr(instr0),
        .if_valid(v0), .if_ready(if_ready), .if_instr(ifi0), .if_pc(ifp0),
        .br_taken(br_taken), .br_offset(br_offset), .jmp_taken(jmp_taken),
        .jmp_target(jmp_target), .halted(h0), .fault(f0));

    fetch_sequencer #(.IMEM_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(addr1), .imem_instr(instr1),
        .if_valid(v1), .if_ready(if_ready), .if_instr(ifi1), .if_pc(ifp1),
        .br_taken(br_taken), .br_offset(br_offset), .jmp_taken(jmp_taken),
        .jmp_target(jmp_target), .halted(h1), .fault(f1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset both DUTs, pulse start; returns with if_pc=0 presented.
    task automatic restart();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_bubble_valid", {31'b0, v0}, 32'd0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[4] = 32'h55; mem[5] = 32'hFFFF_FFFF; mem[10] = 32'hAA;
        rst_n = 1'b0; start = 1'b0; if_ready = 1'b1;
        br_taken = 1'b0; jmp_taken = 1'b0; br_offset = 16'h0; jmp_target = 26'h0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'b0, v0}, 32'd0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_instr", ifi0, 32'd0);
        chk("rst_pc", ifp0, 32'd0);
        chk("rst_halted", {31'b0, h0}, 32'd0);
        chk("rst_fault", {31'b0, f0}, 32'd0);

        // 1: straight-line fetch
        restart();
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", {31'b0, v0}, 32'd1);
            chk("t1_pc", ifp0, 32'(i * 4));
            chk("t1_instr", ifi0, 32'(i + 1) * 32'h11);
            step();
        end

        // 2: stall holds everything
        restart();
        step();
        chk("t2_pc4", ifp0, 32'd4);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_stall_instr", ifi0, 32'h22);
            chk("t2_stall_addr", addr0, 32'd2);
            chk("t2_stall_valid", {31'b0, v0}, 32'd1);
        end
        if_ready = 1'b1;
        step();
        chk("t2_release_pc", ifp0, 32'd8);
        chk("t2_release_instr", ifi0, 32'h33);

        // 3: branch back, then jump beats branch
        restart();
        step(); step();
        chk("t3_at8", ifp0, 32'd8);
        br_taken = 1'b1; br_offset = 16'hFFFE;
        step();
        br_taken = 1'b0;
        chk("t3_br_bubble", {31'b0, v0}, 32'd0);
        chk("t3_br_addr", addr0, 32'd1);
        step();
        chk("t3_br_pc", ifp0, 32'd4);
        chk("t3_br_instr", ifi0, 32'h22);
        step();
        chk("t3_at8b", ifp0, 32'd8);
        jmp_taken = 1'b1; br_taken = 1'b1; jmp_target = 26'd10;
        step();
        jmp_taken = 1'b0; br_taken = 1'b0;
        chk("t3_jmp_bubble", {31'b0, v0}, 32'd0);
        step();
        chk("t3_jmp_pc", ifp0, 32'd40);
        chk("t3_jmp_instr", ifi0, 32'hAA);
        // Redirect without consume is ignored
        if_ready = 1'b0; br_taken = 1'b1;
        step();
        chk("t3_noconsume_pc", ifp0, 32'd40);
        chk("t3_noconsume_valid", {31'b0, v0}, 32'd1);
        if_ready = 1'b1; br_taken = 1'b0;

        // 4: halt
        restart();
        for (int i = 0; i < 5; i++) step();
        chk("t4_haltword_pc", ifp0, 32'd20);
        jmp_taken = 1'b1; jmp_target = 26'd0;
        step();
        jmp_taken = 1'b0;
        chk("t4_halted", {31'b0, h0}, 32'd1);
        chk("t4_halt_valid", {31'b0, v0}, 32'd0);
        chk("t4_halt_addr", addr0, 32'd6);
        start = 1'b1;
        step(); step();
        start = 1'b0;
        chk("t4_still_halted", {31'b0, h0}, 32'd1);
        chk("t4_still_invalid", {31'b0, v0}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_halted", {31'b0, h0}, 32'd0);

        // 5: out-of-range fault with IMEM_DEPTH=4
        restart();
        step(); step(); step();
        chk("t5_pc12", ifp1, 32'd12);
        chk("t5_addr4", addr1, 32'd4);
        chk("t5_nofault", {31'b0, f1}, 32'd0);
        step();
        chk("t5_fault", {31'b0, f1}, 32'd1);
        chk("t5_fault_valid", {31'b0, v1}, 32'd0);
        chk("t5_fault_addr", addr1, 32'd4);
        step();
        chk("t5_fault_sticky", {31'b0, f1}, 32'd1);

        // 6: asynchronous reset mid-stall
        restart();
        step();
        if_ready = 1'b0;
        step();
        chk("t6_stalled_valid", {31'b0, v0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'b0, v0}, 32'd0);
        chk("t6_async_addr", addr0, 32'd0);
        chk("t6_async_pc", ifp0, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
